// File: rtl/flash_record_ctrl_if.sv
// flash_record_ctrl_if: bus between the record controller and the 16x32 flash RAM.
// The controller (master) drives address, write data and write strobe; the RAM
// (slave) returns read data one cycle after an address is presented.
interface flash_record_ctrl_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] add_flash;
   logic [31:0]       write_data_flash;
   logic              flash_write;
   logic [31:0]       data_flash;

   modport master (
      output add_flash,
      output write_data_flash,
      output flash_write,
      input  data_flash
   );

   modport slave (
      input  add_flash,
      input  write_data_flash,
      input  flash_write,
      output data_flash
   );
endinterface

// File: rtl/flash_record_ctrl.sv
// flash_record_ctrl: stores {account, encrypted password} records in flash and
// looks an account up by linear scan of addresses 0..entry_count-1.
// Optional build macro FLASH_OVERWRITE_EN: a store hitting an existing account
// rewrites that record in place instead of reporting dup_err.
module flash_record_ctrl #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                go,
   input  logic                op_store,
   input  logic [15:0]         account,
   input  logic [15:0]         pass_enc_in,
   flash_record_ctrl_if.master flash,
   output logic [15:0]         pass_out,
   output logic                found,
   output logic                full_err,
   output logic                dup_err,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W:0]     entry_count
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_CHECK = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] idx_r, idx_s;
   logic              op_r, op_s;
   logic [15:0]       acct_r, acct_s;
   logic [15:0]       pass_r, pass_s;
   logic              ovw_r, ovw_s;
   logic [ADDR_W-1:0] add_r, add_s;
   logic [31:0]       wdata_r, wdata_s;
   logic              fw_r, fw_s;
   logic [15:0]       pout_r, pout_s;
   logic              found_r, found_s;
   logic              full_r, full_s;
   logic              dup_r, dup_s;
   logic              done_r, done_s;
   logic              busy_r, busy_s;
   logic [ADDR_W:0]   cnt_r, cnt_s;
   logic [ADDR_W:0]   idx_inc_s;
   logic              hit_s;

   // Next-state and next-register values; all outputs are registered from these.
   always_comb begin
      state_s   = state_r;
      idx_s     = idx_r;
      op_s      = op_r;
      acct_s    = acct_r;
      pass_s    = pass_r;
      ovw_s     = ovw_r;
      add_s     = add_r;
      wdata_s   = wdata_r;
      fw_s      = 1'b0;
      pout_s    = pout_r;
      found_s   = found_r;
      full_s    = full_r;
      dup_s     = dup_r;
      done_s    = 1'b0;
      cnt_s     = cnt_r;
      idx_inc_s = {1'b0, idx_r} + ONE_CNT;
      hit_s     = (flash.data_flash[31:16] == acct_r);

      case (state_r)
         ST_IDLE: begin
            if (go) begin
               op_s    = op_store;
               acct_s  = account;
               pass_s  = pass_enc_in;
               found_s = 1'b0;
               full_s  = 1'b0;
               dup_s   = 1'b0;
               ovw_s   = 1'b0;
               idx_s   = {ADDR_W{1'b0}};
               if (cnt_r != {(ADDR_W + 1){1'b0}}) begin
                  state_s = ST_SCAN;
                  add_s   = {ADDR_W{1'b0}};
               end else if (op_store) begin
                  // Empty table: the new record goes straight to address 0.
                  state_s = ST_WRITE;
                  add_s   = cnt_r[ADDR_W-1:0];
                  wdata_s = {account, pass_enc_in};
                  fw_s    = 1'b1;
               end else begin
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_SCAN: begin
            state_s = ST_CHECK;
         end

         ST_CHECK: begin
            if (hit_s) begin
               found_s = 1'b1;
               if (op_r) begin
`ifdef FLASH_OVERWRITE_EN
                  // Rewrite the matching record in place; count unchanged.
                  state_s = ST_WRITE;
                  ovw_s   = 1'b1;
                  add_s   = idx_r;
                  wdata_s = {acct_r, pass_r};
                  fw_s    = 1'b1;
`else
                  dup_s   = 1'b1;
                  state_s = ST_DONE;
                  done_s  = 1'b1;
`endif
               end else begin
                  pout_s  = flash.data_flash[15:0];
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end
            end else if (idx_inc_s < cnt_r) begin
               idx_s   = idx_inc_s[ADDR_W-1:0];
               add_s   = idx_inc_s[ADDR_W-1:0];
               state_s = ST_SCAN;
            end else if (!op_r) begin
               state_s = ST_DONE;
               done_s  = 1'b1;
            end else if (cnt_r == FULL_CNT) begin
               full_s  = 1'b1;
               state_s = ST_DONE;
               done_s  = 1'b1;
            end else begin
               state_s = ST_WRITE;
               add_s   = cnt_r[ADDR_W-1:0];
               wdata_s = {acct_r, pass_r};
               fw_s    = 1'b1;
            end
         end

         ST_WRITE: begin
            if (ovw_r) begin
               cnt_s = cnt_r;
            end else begin
               cnt_s = cnt_r + ONE_CNT;
            end
            state_s = ST_DONE;
            done_s  = 1'b1;
         end

         ST_DONE: begin
            state_s = ST_IDLE;
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      busy_s = (state_s != ST_IDLE);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath, table count and registered outputs; reset erases the table.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r   <= {ADDR_W{1'b0}};
         op_r    <= 1'b0;
         acct_r  <= 16'h0000;
         pass_r  <= 16'h0000;
         ovw_r   <= 1'b0;
         add_r   <= {ADDR_W{1'b0}};
         wdata_r <= 32'h0000_0000;
         fw_r    <= 1'b0;
         pout_r  <= 16'h0000;
         found_r <= 1'b0;
         full_r  <= 1'b0;
         dup_r   <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         cnt_r   <= {(ADDR_W + 1){1'b0}};
      end else begin
         idx_r   <= idx_s;
         op_r    <= op_s;
         acct_r  <= acct_s;
         pass_r  <= pass_s;
         ovw_r   <= ovw_s;
         add_r   <= add_s;
         wdata_r <= wdata_s;
         fw_r    <= fw_s;
         pout_r  <= pout_s;
         found_r <= found_s;
         full_r  <= full_s;
         dup_r   <= dup_s;
         done_r  <= done_s;
         busy_r  <= busy_s;
         cnt_r   <= cnt_s;
      end
   end

   assign flash.add_flash        = add_r;
   assign flash.write_data_flash = wdata_r;
   assign flash.flash_write      = fw_r;
   assign pass_out               = pout_r;
   assign found                  = found_r;
   assign full_err               = full_r;
   assign dup_err                = dup_r;
   assign busy                   = busy_r;
   assign done                   = done_r;
   assign entry_count            = cnt_r;

endmodule

// File: tb/tb_flash_record_ctrl.sv
// tb_flash_record_ctrl: scoreboard bench for flash_record_ctrl with a flash RAM
// model and a record-table reference model computing expected results/latency.
module tb_flash_record_ctrl;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        go = 1'b0;
   logic        op_store = 1'b0;
   logic [15:0] account = 16'h0000;
   logic [15:0] pass_enc_in = 16'h0000;
   logic [15:0] pass_out;
   logic        found, full_err, dup_err, busy, done;
   logic [ADDR_W:0] entry_count;

   flash_record_ctrl_if #(.ADDR_W(ADDR_W)) fbus();

   flash_record_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .go          (go),
      .op_store    (op_store),
      .account     (account),
      .pass_enc_in (pass_enc_in),
      .flash       (fbus),
      .pass_out    (pass_out),
      .found       (found),
      .full_err    (full_err),
      .dup_err     (dup_err),
      .busy        (busy),
      .done        (done),
      .entry_count (entry_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Flash RAM: synchronous write, registered read.
   logic [31:0] mem [DEPTH];
   always @(posedge clk) begin
      if (fbus.flash_write) mem[fbus.add_flash] <= fbus.write_data_flash;
      fbus.data_flash <= mem[fbus.add_flash];
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic note_fail(input string name);
      n_checks++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   typedef struct {
      bit          wr;
      logic [3:0]  waddr;
      logic [31:0] wdata;
      int          wlat;
      int          lat;
      bit          found;
      bit          full;
      bit          dup;
      logic [15:0] pout;
      logic [4:0]  cnt;
      int          go_edge;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: a plain table of records plus the last looked-up password.
   logic [15:0] m_acct [DEPTH];
   logic [15:0] m_pass [DEPTH];
   int          m_cnt  = 0;
   logic [15:0] m_pout = 16'h0000;

   task automatic run_op(input bit st, input logic [15:0] a, input logic [15:0] p);
      exp_t e;
      int   k;
      int   t;
      k = -1;
      for (int i = 0; i < m_cnt; i++) if (k < 0 && m_acct[i] == a) k = i;
      e.wr = 1'b0; e.waddr = 4'h0; e.wdata = 32'h0; e.wlat = 0;
      e.found = 1'b0; e.full = 1'b0; e.dup = 1'b0;
      if (!st) begin
         if (k >= 0) begin
            e.found = 1'b1;
            m_pout  = m_pass[k];
            e.lat   = 2 * k + 3;
         end else begin
            e.lat = 2 * m_cnt + 1;
         end
      end else if (k >= 0) begin
`ifdef FLASH_OVERWRITE_EN
         e.wr = 1'b1; e.waddr = 4'(k); e.wdata = {a, p};
         e.wlat = 2 * k + 3; e.lat = 2 * k + 4; e.found = 1'b1;
         m_pass[k] = p;
`else
         e.dup = 1'b1; e.found = 1'b1; e.lat = 2 * k + 3;
`endif
      end else if (m_cnt == DEPTH) begin
         e.full = 1'b1;
         e.lat  = 2 * m_cnt + 1;
      end else begin
         e.wr = 1'b1; e.waddr = 4'(m_cnt); e.wdata = {a, p};
         e.wlat = 2 * m_cnt + 1; e.lat = e.wlat + 1;
         m_acct[m_cnt] = a;
         m_pass[m_cnt] = p;
         m_cnt++;
      end
      e.pout = m_pout;
      e.cnt  = 5'(m_cnt);
      @(negedge clk);
      e.go_edge = cyc + 1;
      exp_q.push_back(e);
      go = 1'b1; op_store = st; account = a; pass_enc_in = p;
      @(negedge clk);
      go = 1'b0;
      t = 0;
      while (!done && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!done) begin
         note_fail("done_timeout");
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   // Monitor: checks every write strobe and every completion against the queue head.
   initial begin
      int   wr_seen;
      exp_t e;
      wr_seen = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            wr_seen = 0;
         end else begin
            if (fbus.flash_write) begin
               if (exp_q.size() == 0) begin
                  note_fail("unexpected_write");
               end else begin
                  chk("write_addr", 32'(fbus.add_flash), 32'(exp_q[0].waddr));
                  chk("write_data", fbus.write_data_flash, exp_q[0].wdata);
                  chk("write_cycle", 32'(cyc - exp_q[0].go_edge + 1), 32'(exp_q[0].wlat));
               end
               wr_seen++;
            end
            if (done) begin
               if (exp_q.size() == 0) begin
                  note_fail("unexpected_done");
               end else begin
                  e = exp_q.pop_front();
                  chk("done_cycle", 32'(cyc - e.go_edge + 1), 32'(e.lat));
                  chk("found", 32'(found), 32'(e.found));
                  chk("full_err", 32'(full_err), 32'(e.full));
                  chk("dup_err", 32'(dup_err), 32'(e.dup));
                  chk("pass_out", 32'(pass_out), 32'(e.pout));
                  chk("entry_count", 32'(entry_count), 32'(e.cnt));
                  chk("write_count", 32'(wr_seen), 32'(e.wr));
               end
               wr_seen = 0;
            end
         end
      end
   end

   // Stimulus: directed plan followed by randomized operations.
   initial begin
      logic [15:0] a;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_found", 32'(found), 32'h0);
      chk("rst_errs", 32'({full_err, dup_err}), 32'h0);
      chk("rst_pass_out", 32'(pass_out), 32'h0);
      chk("rst_count", 32'(entry_count), 32'h0);
      chk("rst_add", 32'(fbus.add_flash), 32'h0);
      chk("rst_wdata", fbus.write_data_flash, 32'h0);
      chk("rst_write", 32'(fbus.flash_write), 32'h0);

      run_op(1'b0, 16'h0000, 16'h0000);
      run_op(1'b1, 16'h0000, 16'h1236);
      run_op(1'b1, 16'h0001, 16'hA001);
      run_op(1'b1, 16'h0002, 16'hA002);
      run_op(1'b1, 16'h0003, 16'hA003);
      run_op(1'b0, 16'h0002, 16'h0000);
      run_op(1'b0, 16'hBEEF, 16'h0000);
      run_op(1'b1, 16'h0001, 16'h5555);
      run_op(1'b0, 16'h0001, 16'h0000);
      for (int i = 0; i < 12; i++) run_op(1'b1, 16'h0100 + 16'(i), 16'($urandom));
      run_op(1'b1, 16'h0200, 16'h7777);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       a = 16'($urandom_range(0, 3));
            1:       a = 16'h0100 + 16'($urandom_range(0, 15));
            2:       a = 16'($urandom);
            default: a = m_acct[$urandom_range(0, DEPTH - 1)];
         endcase
         run_op(1'($urandom_range(0, 1)), a, 16'($urandom));
      end

      // Reset in the middle of a long scan.
      @(negedge clk);
      go = 1'b1; op_store = 1'b0; account = 16'hBEEF;
      @(negedge clk);
      go = 1'b0;
      repeat (3) @(negedge clk);
      chk("midscan_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_count", 32'(entry_count), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      rst = 1'b0;
      m_cnt  = 0;
      m_pout = 16'h0000;

      for (int i = 0; i < 60; i++) begin
         run_op(1'($urandom_range(0, 1)), 16'($urandom_range(0, 19)), 16'($urandom));
      end
      run_op(1'b0, 16'h0000, 16'h0000);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/flash_record_ctrl.md
Name: flash_record_ctrl

Overview:
- Record manager between the password encryption core and the 16x32 flash RAM.
- Stores {account, encrypted password} records and looks up an account's encrypted password by linear scan.
- Downstream of the encryptor, whose `password_enc` feeds `pass_enc_in`; upstream of the decryptor, which consumes `pass_out`.
- Owns the entry count, the flash address, the write data and the write strobe.

Parameters:
- DEPTH, 16, number of flash records; must be 2**ADDR_W.
- ADDR_W, 4, flash address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled only in IDLE.
- op_store  in  1  1 = store record, 0 = lookup; latched with go.
- account  in  16  account ID; latched with go.
- pass_enc_in  in  16  encrypted password to store; latched with go.
- data_flash  in  32  RAM read data; valid one cycle after add_flash is presented.
- add_flash  out  ADDR_W  RAM address.
- write_data_flash  out  32  {account, pass_enc}.
- flash_write  out  1  RAM write enable; high for one cycle.
- pass_out  out  16  encrypted password found by lookup.
- found  out  1  account matched during the last operation.
- full_err  out  1  store refused because the table is full.
- dup_err  out  1  store refused because the account already exists (macro off only).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- entry_count  out  ADDR_W+1  number of valid records (0..DEPTH).

Behaviour:
- Reset: state IDLE; every output 0, including add_flash, write_data_flash, pass_out and entry_count.
- Reset mid-operation aborts with no write, and clears entry_count (table logically erased).
- Record format: bits [31:16] account, bits [15:0] encrypted password. Valid records occupy addresses 0..entry_count-1.
- add_flash is a register: it holds idx in SCAN/CHECK and the write address in WRITE.
- IDLE, on go=1:
  - latch op_store, account and pass_enc_in;
  - clear found, full_err and dup_err;
  - set idx=0;
  - go to SCAN if entry_count>0, else to WRITE (store) or DONE (lookup).
- IDLE, on go=0: stay in IDLE.
- SCAN: present add_flash=idx; next state CHECK.
- CHECK: compare data_flash[31:16] with the latched account.
  - Match, lookup: pass_out <= data_flash[15:0], found=1, go to DONE.
  - Match, store: see Optional Feature.
  - Miss with idx+1<entry_count: idx++, go to SCAN.
  - Miss on the last record, lookup: found=0, go to DONE; pass_out holds its previous value.
  - Miss on the last record, store with entry_count==DEPTH: full_err=1, go to DONE, no write.
  - Miss on the last record, store otherwise: go to WRITE.
- WRITE (new record):
  - add_flash=entry_count[ADDR_W-1:0], write_data_flash={account, pass_enc}, flash_write=1 for exactly this cycle;
  - entry_count++; go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
  - found, full_err, dup_err and pass_out hold until the next accepted go.
- go is ignored while busy. A go held high through DONE starts a new operation on the first IDLE cycle.
- Latency counts cycles after the go-sampling edge (that edge is cycle 0):
  - hit at index k: done in cycle 2k+3;
  - lookup miss with n records: done in cycle 2n+1;
  - store miss: write in cycle 2n+1, done in cycle 2n+2;
  - empty table: lookup done in cycle 1; store writes in cycle 1, done in cycle 2.
- Duplicate-match rule: the first (lowest-address) match wins.
- Account 16'h0000 is a legal ID; emptiness is defined only by entry_count.

Optional Feature:
- Macro: FLASH_OVERWRITE_EN.
- Defined: a store that matches at idx goes to WRITE at address idx.
  - Writes the new {account, pass_enc}, sets found=1, leaves entry_count unchanged, dup_err tied 0.
  - Hit latency: write in cycle 2k+3, done in cycle 2k+4.
- Undefined: a store that matches sets dup_err=1 and found=1, goes to DONE, and performs no write.

Test Plan:
- Reset, then lookup account 16'h0000 on the empty table -> done in cycle 1, found=0, flash_write never asserted, entry_count=0.
- Store account 16'h0000 with pass 16'h1236 -> flash_write pulse at add_flash=0, write_data_flash=32'h00001236, entry_count=1, done one cycle later.
- Store accounts 16'h0001..16'h0003 (passes 16'hA001..16'hA003), then look up 16'h0002 -> found=1, pass_out=16'hA002, done in cycle 2*2+3=7.
- Look up absent account 16'hBEEF with 4 records -> found=0, done in cycle 9, pass_out unchanged.
- Fill all 16 records, then store a new account -> full_err=1, no flash_write, entry_count stays 16.
- Store 16'h0001 again with pass 16'h5555:
  - macro off -> dup_err=1, no write;
  - macro on -> write at address 1, then lookup returns 16'h5555.
  - Also assert rst mid-scan -> busy drops the next cycle and entry_count=0.
